scoreboard_hazard_unit: RTL

SCOREBOARD_HAZARD_UNIT -- requirements
Module: scoreboard_hazard_unit

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/md_tracker.sv | 65 ++++++
 rtl/scoreboard_hazard_unit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the scoreboard hazard unit: mul/div tracker states,
// ALU operand source encodings and the default mul/div latency.
package hazard_pkg;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01,
        MD_DONE = 2'b10
    } md_state_t;

    typedef enum logic [1:0] {
        SRC_RF = 2'b00,
        SRC_WB = 2'b01,
        SRC_M  = 2'b10,
        SRC_MD = 2'b11
    } src_sel_t;

    localparam int MD_LAT_DEF = 4;
    localparam int MD_CNT_W   = 4;

endpackage

// File: rtl/md_tracker.sv
// Tracks one in-flight mul/div: IDLE -> BUSY (counting) -> DONE (one cycle).
// Ports: clk, rst, start/rd_key (issue), freeze (D-cache miss holds state),
// md_wb_sel/md_busy/md_rd (status), md_fwd (first cycle after DONE).
module md_tracker
    import hazard_pkg::*;
#(
    parameter int KEY_W  = 5,
    parameter int MD_LAT = MD_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             freeze,
    input  logic [KEY_W-1:0] rd_key,
    output logic             md_wb_sel,
    output logic             md_busy,
    output logic             md_fwd,
    output logic [KEY_W-1:0] md_rd
);

    md_state_t             state;
    logic [MD_CNT_W-1:0]   cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= MD_IDLE;
            cnt       <= '0;
            md_rd     <= '0;
            md_wb_sel <= 1'b0;
            md_busy   <= 1'b0;
            md_fwd    <= 1'b0;
        end else if (!freeze) begin
            unique case (state)
                MD_IDLE: begin
                    md_fwd <= 1'b0;
                    if (start) begin
                        state   <= MD_BUSY;
                        cnt     <= MD_CNT_W'(MD_LAT - 1);
                        md_rd   <= rd_key;
                        md_busy <= 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (cnt == MD_CNT_W'(1)) begin
                        state     <= MD_DONE;
                        md_wb_sel <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                MD_DONE: begin
                    // Result leaves via WB now; E may bypass it next cycle.
                    state     <= MD_IDLE;
                    md_wb_sel <= 1'b0;
                    md_busy   <= 1'b0;
                    md_fwd    <= 1'b1;
                end
                default: begin
                    state <= MD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use / mul/div stalls,
// branch and cache-miss flushes. Inputs are D/E/M/WB stage keys and
// events; outputs are ALU source selects, stall/flush enables, md status.
module scoreboard_hazard_unit
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int KEY_W    = $clog2(NUM_REGS),
    parameter int MD_LAT   = MD_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             icache_hit,
    input  logic             dcache_hit,
    input  logic             m_in_is_mem,
    input  logic [KEY_W-1:0] d_in_r1_key,
    input  logic [KEY_W-1:0] d_in_r2_key,
    input  logic             d_in_is_md,
    input  logic [KEY_W-1:0] e_in_r1_key,
    input  logic [KEY_W-1:0] e_in_r2_key,
    input  logic [KEY_W-1:0] e_in_rd_key,
    input  logic             e_in_rd_is_load_en,
    input  logic             e_in_branch_en,
    input  logic             e_in_md_start,
    input  logic [KEY_W-1:0] m_in_rd_key,
    input  logic             m_in_rd_we,
    input  logic [KEY_W-1:0] wb_in_rd_key,
    input  logic             wb_in_rd_we,
    output logic [1:0]       hu_out_alu_src1_sel,
    output logic [1:0]       hu_out_alu_src2_sel,
    output logic             hu_out_stall_f_en,
    output logic             hu_out_stall_d_en,
    output logic             hu_out_stall_e_en,
    output logic             hu_out_stall_m_en,
    output logic             hu_out_flush_d_en,
    output logic             hu_out_flush_e_en,
    output logic             hu_out_flush_wb_en,
    output logic             hu_out_md_wb_sel,
    output logic             hu_out_md_busy,
    output logic [KEY_W-1:0] hu_out_md_rd_key
);

    logic dc_miss;
    logic md_fwd;
    logic md_dep;
    logic load_use;
    logic data_haz;

    assign dc_miss = m_in_is_mem & ~dcache_hit;

    md_tracker #(
        .KEY_W  (KEY_W),
        .MD_LAT (MD_LAT)
    ) u_md (
        .clk       (clk),
        .rst       (rst),
        .start     (e_in_md_start),
        .freeze    (dc_miss),
        .rd_key    (e_in_rd_key),
        .md_wb_sel (hu_out_md_wb_sel),
        .md_busy   (hu_out_md_busy),
        .md_fwd    (md_fwd),
        .md_rd     (hu_out_md_rd_key)
    );

    function automatic src_sel_t fwd_sel(input logic [KEY_W-1:0] k);
        if (k == '0)
            return SRC_RF;
        else if (md_fwd && k == hu_out_md_rd_key)
            return SRC_MD;
        else if (m_in_rd_we && k == m_in_rd_key)
            return SRC_M;
        else if (wb_in_rd_we && k == wb_in_rd_key)
            return SRC_WB;
        else
            return SRC_RF;
    endfunction

    always_comb begin
        hu_out_alu_src1_sel = fwd_sel(e_in_r1_key);
        hu_out_alu_src2_sel = fwd_sel(e_in_r2_key);
    end

    assign load_use = e_in_rd_is_load_en && (e_in_rd_key != '0) &&
                      ((e_in_rd_key == d_in_r1_key) ||
                       (e_in_rd_key == d_in_r2_key));

    assign md_dep = hu_out_md_busy && (hu_out_md_rd_key != '0) &&
                    ((hu_out_md_rd_key == d_in_r1_key) ||
                     (hu_out_md_rd_key == d_in_r2_key));

    assign data_haz = load_use | md_dep | (hu_out_md_busy & d_in_is_md);

    always_comb begin
        hu_out_stall_f_en  = 1'b0;
        hu_out_stall_d_en  = 1'b0;
        hu_out_stall_e_en  = 1'b0;
        hu_out_stall_m_en  = 1'b0;
        hu_out_flush_d_en  = 1'b0;
        hu_out_flush_e_en  = 1'b0;
        hu_out_flush_wb_en = 1'b0;
        // A D-cache miss or the mul/div WB slot freezes the whole pipe.
        if (dc_miss || hu_out_md_wb_sel) begin
            hu_out_stall_f_en  = 1'b1;
            hu_out_stall_d_en  = 1'b1;
            hu_out_stall_e_en  = 1'b1;
            hu_out_stall_m_en  = 1'b1;
            hu_out_flush_wb_en = 1'b1;
        end else begin
            // The branch kills the stalled consumer, so no stall is needed.
            if (e_in_branch_en) begin
                hu_out_flush_d_en = 1'b1;
                hu_out_flush_e_en = 1'b1;
            end else if (data_haz) begin
                hu_out_stall_f_en = 1'b1;
                hu_out_stall_d_en = 1'b1;
                hu_out_flush_e_en = 1'b1;
            end
            if (!icache_hit) begin
                hu_out_stall_f_en = 1'b1;
                if (!hu_out_stall_d_en)
                    hu_out_flush_d_en = 1'b1;
            end
        end
    end

endmodule
